// File: rtl/bp_fe_queue_buffer_if.sv
// Handshake bundle between the front end, the speculative FE queue buffer and the back end.
//
// Signal directions are named from the buffer's point of view (_i = into the buffer,
// _o = out of the buffer):
//   fe_queue_i / fe_queue_v_i / fe_queue_ready_o : enqueue channel from the front end
//   fe_queue_o / fe_queue_v_o / fe_queue_yumi_i  : read channel to the back end
//   clr_v_i                                      : flush all entries
//   deq_v_i                                      : commit the oldest read entry
//   roll_v_i                                     : rewind reads to the commit point
//   count_o                                      : occupancy including read-uncommitted entries
//
// Modports:
//   slave  : the buffer itself
//   master : the environment (front end + back end) that drives the buffer
interface bp_fe_queue_buffer_if #(
  parameter int unsigned entry_width_p = 128,
  parameter int unsigned els_p         = 8
);
  localparam int unsigned count_width_lp = $clog2(els_p + 1);

  logic [entry_width_p-1:0]  fe_queue_i;
  logic                      fe_queue_v_i;
  logic                      fe_queue_ready_o;
  logic [entry_width_p-1:0]  fe_queue_o;
  logic                      fe_queue_v_o;
  logic                      fe_queue_yumi_i;
  logic                      clr_v_i;
  logic                      deq_v_i;
  logic                      roll_v_i;
  logic [count_width_lp-1:0] count_o;

  modport slave (
    input  fe_queue_i,
    input  fe_queue_v_i,
    output fe_queue_ready_o,
    output fe_queue_o,
    output fe_queue_v_o,
    input  fe_queue_yumi_i,
    input  clr_v_i,
    input  deq_v_i,
    input  roll_v_i,
    output count_o
  );

  modport master (
    output fe_queue_i,
    output fe_queue_v_i,
    input  fe_queue_ready_o,
    input  fe_queue_o,
    input  fe_queue_v_o,
    output fe_queue_yumi_i,
    output clr_v_i,
    output deq_v_i,
    output roll_v_i,
    input  count_o
  );
endinterface

// File: rtl/bp_fe_queue_buffer.sv
// Speculative FIFO between the front-end fetch output and the back-end issue stage.
//
// Messages enqueued by the front end are presented oldest-first to the back end. An entry
// read by the back end (yumi) stays in the buffer until it is committed (deq), so a rollback
// can replay every read-but-uncommitted entry. A flush (clr) discards everything.
//
// Ports:
//   clk_i     : clock, all state updates on the rising edge
//   reset_n_i : synchronous active-low reset, highest priority
//   fe_if     : slave side of bp_fe_queue_buffer_if (enqueue, read, commit, roll, flush, count)
//
// Three pointers carry one extra wrap bit so full and empty are distinguishable:
//   cptr_q <= rptr_q <= wptr_q (modulo 2*els_p)
module bp_fe_queue_buffer #(
  parameter int unsigned entry_width_p = 128,
  parameter int unsigned els_p         = 8
) (
  input logic                clk_i,
  input logic                reset_n_i,
  bp_fe_queue_buffer_if.slave fe_if
);

  localparam int unsigned ptr_width_lp   = $clog2(els_p) + 1;
  localparam int unsigned count_width_lp = $clog2(els_p + 1);
  localparam int unsigned idx_width_lp   = ptr_width_lp - 1;

  typedef logic [ptr_width_lp-1:0] ptr_t;

  localparam ptr_t PtrOne  = ptr_t'(1);
  localparam ptr_t PtrFull = ptr_t'(els_p);

  // Storage, intentionally not reset: validity is tracked by the pointers alone.
  logic [entry_width_p-1:0] mem_q [els_p];

  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  ptr_t cptr_q, cptr_d;

  ptr_t occupancy;
  logic full;
  logic enq_en;

  // Status is derived from registers only; a same-cycle deq does not open up space.
  assign occupancy = wptr_q - cptr_q;
  assign full      = (occupancy == PtrFull);
  assign enq_en    = fe_if.fe_queue_v_i & ~full;

  assign fe_if.fe_queue_ready_o = ~full;
  assign fe_if.fe_queue_v_o     = (rptr_q != wptr_q);
  assign fe_if.count_o          = count_width_lp'(occupancy);

  // No bypass: the output only ever shows what is already stored.
  always_comb begin
    fe_if.fe_queue_o = '0;
    if (fe_if.fe_queue_v_o) begin
      fe_if.fe_queue_o = mem_q[rptr_q[idx_width_lp-1:0]];
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    cptr_d = cptr_q;
    rptr_d = rptr_q;
    if (fe_if.clr_v_i) begin
      wptr_d = '0;
      cptr_d = '0;
      rptr_d = '0;
    end else begin
      if (enq_en) begin
        wptr_d = wptr_q + PtrOne;
      end
      if (fe_if.deq_v_i) begin
        cptr_d = cptr_q + PtrOne;
      end
      // Roll targets the post-deq commit point and overrides a same-cycle yumi.
      if (fe_if.roll_v_i) begin
        rptr_d = cptr_d;
      end else if (fe_if.fe_queue_yumi_i) begin
        rptr_d = rptr_q + PtrOne;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  // A flushed or reset enqueue never lands in storage.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && enq_en && !fe_if.clr_v_i) begin
      mem_q[wptr_q[idx_width_lp-1:0]] <= fe_if.fe_queue_i;
    end
  end

  // Protocol checks on the environment.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && !fe_if.clr_v_i) begin
      assert (!(fe_if.deq_v_i && (cptr_q == rptr_q)))
        else $error("bp_fe_queue_buffer: deq with no read-uncommitted entry");
      assert (!(fe_if.fe_queue_v_i && full))
        else $error("bp_fe_queue_buffer: enqueue while full");
    end
  end

endmodule

// File: tb/tb_bp_fe_queue_buffer.sv
module tb_bp_fe_queue_buffer;

  localparam int unsigned W = 16;
  localparam int unsigned E = 4;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  bp_fe_queue_buffer_if #(.entry_width_p(W), .els_p(E)) q_if ();

  bp_fe_queue_buffer #(.entry_width_p(W), .els_p(E)) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .fe_if    (q_if)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    q_if.fe_queue_i      = '0;
    q_if.fe_queue_v_i    = 1'b0;
    q_if.fe_queue_yumi_i = 1'b0;
    q_if.clr_v_i         = 1'b0;
    q_if.deq_v_i         = 1'b0;
    q_if.roll_v_i        = 1'b0;
  endtask

  task automatic enq(input logic [W-1:0] d);
    q_if.fe_queue_v_i = 1'b1;
    q_if.fe_queue_i   = d;
    tick();
    q_if.fe_queue_v_i = 1'b0;
    q_if.fe_queue_i   = '0;
  endtask

  task automatic flush();
    q_if.clr_v_i = 1'b1;
    tick();
    q_if.clr_v_i = 1'b0;
  endtask

  task automatic status(input string tag, input logic v, input logic rdy, input logic [31:0] cnt);
    check({tag, ".v"},     32'(q_if.fe_queue_v_o),     32'(v));
    check({tag, ".ready"}, 32'(q_if.fe_queue_ready_o), 32'(rdy));
    check({tag, ".count"}, 32'(q_if.count_o),          cnt);
  endtask

  task automatic data(input string tag, input logic [31:0] exp);
    check({tag, ".data"}, 32'(q_if.fe_queue_o), exp);
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    status("reset", 1'b0, 1'b1, 0);
    data("reset", 32'h0);

    // Basic flow
    q_if.fe_queue_v_i = 1'b1;
    q_if.fe_queue_i   = 16'h0001;
    tick();
    status("t1_first", 1'b1, 1'b1, 1);
    data("t1_first", 32'h0001);
    q_if.fe_queue_i = 16'h0002;
    tick();
    q_if.fe_queue_i = 16'h0003;
    tick();
    idle();
    status("t1_three", 1'b1, 1'b1, 3);
    data("t1_rd0", 32'h0001);
    q_if.fe_queue_yumi_i = 1'b1;
    tick();
    data("t1_rd1", 32'h0002);
    tick();
    data("t1_rd2", 32'h0003);
    tick();
    q_if.fe_queue_yumi_i = 1'b0;
    status("t1_read", 1'b0, 1'b1, 3);
    data("t1_read", 32'h0);
    q_if.deq_v_i = 1'b1;
    tick();
    check("t1_deq1.count", 32'(q_if.count_o), 2);
    tick();
    tick();
    q_if.deq_v_i = 1'b0;
    status("t1_deq", 1'b0, 1'b1, 0);
    flush();

    // Full and wrap
    enq(16'h0011);
    enq(16'h0012);
    enq(16'h0013);
    enq(16'h0014);
    status("t2_full", 1'b1, 1'b0, 4);
    data("t2_full", 32'h0011);
    q_if.fe_queue_yumi_i = 1'b1;
    tick();
    data("t2_y1", 32'h0012);
    tick();
    q_if.fe_queue_yumi_i = 1'b0;
    status("t2_y2", 1'b1, 1'b0, 4);
    q_if.deq_v_i = 1'b1;
    tick();
    status("t2_deq1", 1'b1, 1'b1, 3);
    tick();
    q_if.deq_v_i = 1'b0;
    check("t2_deq2.count", 32'(q_if.count_o), 2);
    enq(16'h00AA);
    enq(16'h00BB);
    status("t2_wrap", 1'b1, 1'b0, 4);
    data("t2_rd13", 32'h0013);
    q_if.fe_queue_yumi_i = 1'b1;
    tick();
    data("t2_rd14", 32'h0014);
    tick();
    data("t2_rdAA", 32'h00AA);
    tick();
    data("t2_rdBB", 32'h00BB);
    tick();
    q_if.fe_queue_yumi_i = 1'b0;
    status("t2_drained", 1'b0, 1'b0, 4);
    flush();
    status("t2_flush", 1'b0, 1'b1, 0);

    // Rollback
    enq(16'h0010);
    enq(16'h0020);
    enq(16'h0030);
    q_if.fe_queue_yumi_i = 1'b1;
    tick();
    tick();
    q_if.fe_queue_yumi_i = 1'b0;
    data("t3_y2", 32'h0030);
    q_if.deq_v_i = 1'b1;
    tick();
    q_if.deq_v_i = 1'b0;
    q_if.roll_v_i = 1'b1;
    tick();
    q_if.roll_v_i = 1'b0;
    data("t3_roll", 32'h0020);
    status("t3_roll", 1'b1, 1'b1, 2);
    flush();

    // Roll with same-cycle deq and yumi
    enq(16'h0041);
    enq(16'h0042);
    enq(16'h0043);
    q_if.fe_queue_yumi_i = 1'b1;
    tick();
    tick();
    tick();
    q_if.fe_queue_yumi_i = 1'b0;
    status("t4_read", 1'b0, 1'b1, 3);
    q_if.deq_v_i         = 1'b1;
    q_if.roll_v_i        = 1'b1;
    q_if.fe_queue_yumi_i = 1'b1;
    tick();
    idle();
    data("t4_roll", 32'h0042);
    status("t4_roll", 1'b1, 1'b1, 2);
    flush();

    // Flush priority over enqueue and yumi
    enq(16'h0051);
    enq(16'h0052);
    enq(16'h0053);
    q_if.clr_v_i         = 1'b1;
    q_if.fe_queue_v_i    = 1'b1;
    q_if.fe_queue_i      = 16'h0055;
    q_if.fe_queue_yumi_i = 1'b1;
    tick();
    idle();
    status("t5_clr", 1'b0, 1'b1, 0);
    data("t5_clr", 32'h0);
    tick();
    status("t5_after", 1'b0, 1'b1, 0);
    enq(16'h0066);
    data("t5_new", 32'h0066);
    check("t5_new.count", 32'(q_if.count_o), 1);
    flush();

    // Mid-operation reset
    enq(16'h0061);
    enq(16'h0062);
    q_if.fe_queue_yumi_i = 1'b1;
    tick();
    q_if.fe_queue_yumi_i = 1'b0;
    data("t6_pre", 32'h0062);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    status("t6_reset", 1'b0, 1'b1, 0);
    data("t6_reset", 32'h0);
    enq(16'h0077);
    status("t6_enq", 1'b1, 1'b1, 1);
    data("t6_enq", 32'h0077);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
